// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: frame controller for the UART receiver.
//   Owns the per-bit edge counter and the frame bit counter. It sequences the
//   start, data, optional parity and stop phases, and drives the enables for
//   the sampler, deserializer and checkers. It drops a frame on a start glitch
//   or a parity error, and pulses data_valid_o for one clk after a good stop bit.
// Ports:
//   clk            receiver clock (prescale x baud)
//   rst            synchronous, active-low reset
//   rx_in_i        synchronised serial line, idle high
//   par_en_i       frame carries a parity bit (latched at frame start)
//   prescale_i     clocks per bit (latched at frame start)
//   strt_glitch_i  registered start-checker flag
//   par_err_i      registered parity-checker flag
//   stop_err_i     registered stop-checker flag
//   edge_count_o   clock index within the current bit
//   bit_count_o    bit index in the frame: 0=start, 1..DATA_W=data, then parity/stop
//   *_en_o         registered enables to the datapath blocks
//   data_valid_o   one-cycle pulse per good frame
module uart_rx_ctrl #(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in_i,
  input  logic                  par_en_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic                  strt_glitch_i,
  input  logic                  par_err_i,
  input  logic                  stop_err_i,
  output logic [PRESCALE_W-1:0] edge_count_o,
  output logic [BIT_CNT_W-1:0]  bit_count_o,
  output logic                  dat_samp_en_o,
  output logic                  strt_chk_en_o,
  output logic                  deser_en_o,
  output logic                  par_chk_en_o,
  output logic                  stop_chk_en_o,
  output logic                  data_valid_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic                  pe_q, pe_d;
  logic                  samp_q, samp_d;
  logic                  strt_q, strt_d;
  logic                  deser_q, deser_d;
  logic                  par_q, par_d;
  logic                  stop_q, stop_d;
  logic                  dv_q, dv_d;

  logic                  last;
  logic [PRESCALE_W-1:0] edge_inc;

  // The edge counter wraps at P-1. With an illegal prescale the compare still
  // hits within one full counter wrap, so the frame always terminates.
  assign last     = (edge_q == p_q - PRESCALE_W'(1));
  assign edge_inc = last ? '0 : edge_q + PRESCALE_W'(1);

  always_comb begin
    state_d = state_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
    p_d     = p_q;
    pe_d    = pe_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (!rx_in_i) begin
          state_d = START;
          p_d     = prescale_i;
          pe_d    = par_en_i;
        end
      end
      START: begin
        edge_d = edge_inc;
        if (last) begin
          if (strt_glitch_i) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            state_d = DATA;
            bit_d   = BIT_CNT_W'(1);
          end
        end
      end
      DATA: begin
        edge_d = edge_inc;
        if (last) begin
          bit_d = bit_q + BIT_CNT_W'(1);
          if (bit_q == BIT_CNT_W'(DATA_W)) state_d = pe_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        edge_d = edge_inc;
        if (last) begin
          if (par_err_i) begin
            state_d = IDLE;
            bit_d   = '0;
          end else begin
            state_d = STOP;
            bit_d   = bit_q + BIT_CNT_W'(1);
          end
        end
      end
      STOP: begin
        edge_d = edge_inc;
        if (last) begin
          state_d = IDLE;
          bit_d   = '0;
          dv_d    = !stop_err_i;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Enables are decoded from the next state so they line up with the
  // registered counters. deser fires at edge H+2, one clk after the checkers'
  // majority becomes valid.
  always_comb begin
    samp_d  = (state_d != IDLE);
    strt_d  = (state_d == START);
    deser_d = (state_d == DATA) && (edge_d == (p_d >> 1) + PRESCALE_W'(2));
    par_d   = (state_d == PARITY);
    stop_d  = (state_d == STOP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      edge_q  <= '0;
      bit_q   <= '0;
      p_q     <= '0;
      pe_q    <= 1'b0;
      samp_q  <= 1'b0;
      strt_q  <= 1'b0;
      deser_q <= 1'b0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
      p_q     <= p_d;
      pe_q    <= pe_d;
      samp_q  <= samp_d;
      strt_q  <= strt_d;
      deser_q <= deser_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      dv_q    <= dv_d;
    end
  end

  assign edge_count_o  = edge_q;
  assign bit_count_o   = bit_q;
  assign dat_samp_en_o = samp_q;
  assign strt_chk_en_o = strt_q;
  assign deser_en_o    = deser_q;
  assign par_chk_en_o  = par_q;
  assign stop_chk_en_o = stop_q;
  assign data_valid_o  = dv_q;

endmodule
